// File: rtl/srl_delay_ctrl.sv
// Programmable-length delay line with valid/ready handshakes.
// A word is emitted only when a new word is accepted len accepts later;
// flush drains the stored words oldest first.
module srl_delay_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     r,
  input  logic                     cfg_we,
  input  logic [$clog2(DEPTH):0]   cfg_len,
  output logic                     cfg_err,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     flush,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] FLUSH = 2'd3;

  logic [1:0]       state;
  logic [LW-1:0]    len;
  logic [LW-1:0]    cnt;
  logic [WIDTH-1:0] sr [DEPTH];

  logic             accept;
  logic             consume;
  logic             out_free;
  logic             cfg_ok;
  logic [LW-1:0]    len_m1;
  logic [LW-1:0]    cnt_m1;
  logic [LW-1:0]    cnt_p1;
  logic [WIDTH-1:0] sr_len;
  logic [WIDTH-1:0] sr_cnt;

  assign accept   = in_valid & in_ready;
  assign consume  = out_valid & out_ready;
  assign out_free = ~out_valid | out_ready;
  assign cfg_ok   = (cfg_len != '0) && (cfg_len <= LW'(DEPTH));
  assign len_m1   = len - LW'(1);
  assign cnt_m1   = cnt - LW'(1);
  assign cnt_p1   = cnt + LW'(1);
  assign sr_len   = sr[len_m1[AW-1:0]];
  assign sr_cnt   = sr[cnt_m1[AW-1:0]];
  assign busy     = (state != IDLE);

  // Input readiness depends on state and on whether the output slot frees up
  always_comb begin
    in_ready = 1'b0;
    case (state)
      IDLE:    in_ready = 1'b1;
      FILL:    in_ready = 1'b1;
      RUN:     in_ready = out_free;
      default: in_ready = 1'b0;
    endcase
  end

  // Storage shifts once per accepted word; left unreset so it maps onto shift-register primitives
  always_ff @(posedge clk) begin
    if (accept) begin
      sr[0] <= in_data;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        sr[k] <= sr[k-1];
      end
    end
  end

  // Control: state, fill count, delay length, output register and config error pulse
  always_ff @(posedge clk) begin
    if (r) begin
      state     <= IDLE;
      cnt       <= '0;
      len       <= LW'(DEPTH);
      out_valid <= 1'b0;
      out_data  <= '0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      if (consume) out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_we) begin
            if (cfg_ok) len <= cfg_len;
            else        cfg_err <= 1'b1;
          end
          // decision uses the register value, i.e. the length before any same-cycle write
          if (accept) begin
            cnt   <= LW'(1);
            state <= (len == LW'(1)) ? RUN : FILL;
          end
        end
        FILL: begin
          if (accept) begin
            cnt <= cnt_p1;
            // >= keeps FILL from stalling if len was shortened on the entering cycle
            if (cnt_p1 >= len) state <= RUN;
          end
          if (flush) state <= FLUSH;
        end
        RUN: begin
          if (accept) begin
            out_data  <= sr_len;
            out_valid <= 1'b1;
          end
          if (flush) state <= FLUSH;
        end
        FLUSH: begin
          if (out_free) begin
            if (cnt != '0) begin
              out_data  <= sr_cnt;
              out_valid <= 1'b1;
              cnt       <= cnt_m1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
